// File: rtl/bitcnt_arbiter_if.sv
// Requester and response bundle for bitcnt_arbiter: NREQ request lanes in,
// one tagged result lane out, plus the accepted-response counter.
interface bitcnt_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) ();
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*64-1:0] req_data;
    logic [NREQ*3-1:0]  req_func;

    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [63:0]        rsp_data;
    logic               rsp_err;
    logic [31:0]        ops_count;

    modport master (
        output req_valid, req_data, req_func, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, ops_count
    );

    modport slave (
        input  req_valid, req_data, req_func, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, ops_count
    );
endinterface

// File: rtl/bitcnt_arbiter.sv
// Round-robin arbiter feeding a shared CLZ/CTZ/POPCNT unit through a two-stage
// registered pipeline; each response is tagged with the issuing requester.
module bitcnt_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input logic              clk,
    input logic              reset,
    bitcnt_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        FN_CLZ64 = 3'b000,
        FN_CLZ32 = 3'b001,
        FN_CTZ64 = 3'b010,
        FN_CTZ32 = 3'b011,
        FN_POP64 = 3'b100,
        FN_POP32 = 3'b101
    } func_e;

    function automatic logic [6:0] clz64(input logic [63:0] v);
        logic [6:0] n;
        logic       done;
        n    = 7'd0;
        done = 1'b0;
        for (int i = 63; i >= 0; i--) begin
            if (!done) begin
                if (v[i]) done = 1'b1;
                else      n    = n + 7'd1;
            end
        end
        return n;
    endfunction

    function automatic logic [6:0] ctz64(input logic [63:0] v);
        logic [6:0] n;
        logic       done;
        n    = 7'd0;
        done = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (!done) begin
                if (v[i]) done = 1'b1;
                else      n    = n + 7'd1;
            end
        end
        return n;
    endfunction

    function automatic logic [6:0] pop64(input logic [63:0] v);
        logic [6:0] n;
        n = 7'd0;
        for (int i = 0; i < 64; i++) n = n + {6'd0, v[i]};
        return n;
    endfunction

    // Pipeline state
    logic            s1_valid;
    logic [63:0]     s1_data;
    logic [2:0]      s1_func;
    logic [IDW-1:0]  s1_id;

    logic            s2_valid;
    logic [63:0]     s2_data;
    logic            s2_err;
    logic [IDW-1:0]  s2_id;

    logic [IDW-1:0]  ptr;
    logic [31:0]     ops_q;

    // Arbitration and advance control
    logic            s2_free;
    logic            s1_to_s2;
    logic            s1_free;
    logic            grant_found;
    logic [IDW-1:0]  grant_id;
    logic            grant_fire;
    logic [63:0]     sel_data;
    logic [2:0]      sel_func;

    logic [63:0]     bc_result;
    logic            bc_err;

    assign s2_free  = !s2_valid || bus.rsp_ready;
    assign s1_to_s2 = s1_valid && s2_free;
    assign s1_free  = !s1_valid || s1_to_s2;

    // NOTE: every variable driven here gets a default before the loop, so no latch is inferred.
    always_comb begin
        int             idx;
        logic [IDW-1:0] cand;
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = IDW'(idx);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    // Holding reset keeps every requester out even though S1 reads as free.
    assign grant_fire    = grant_found && s1_free && !reset;
    assign bus.req_ready = grant_fire ? (NREQ'(1) << grant_id) : '0;

    always_comb begin
        sel_data = '0;
        sel_func = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == IDW'(i)) begin
                sel_data = bus.req_data[64*i +: 64];
                sel_func = bus.req_func[3*i +: 3];
            end
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr      <= '0;
            s1_valid <= 1'b0;
        end else begin
            if (grant_fire) begin
                ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
            end
            if (grant_fire)    s1_valid <= 1'b1;
            else if (s1_to_s2) s1_valid <= 1'b0;
        end
    end

    // NOTE: the S1 payload has no reset; s1_valid qualifies it, so stale contents are never used.
    always_ff @(posedge clk) begin
        if (grant_fire) begin
            s1_data <= sel_data;
            s1_func <= sel_func;
            s1_id   <= grant_id;
        end
    end

    always_comb begin
        bc_result = '0;
        bc_err    = 1'b0;
        case (s1_func)
            FN_CLZ64: bc_result = {57'd0, clz64(s1_data)};
            FN_CLZ32: bc_result = {57'd0, clz64({s1_data[31:0], 32'hFFFF_FFFF})};
            FN_CTZ64: bc_result = {57'd0, ctz64(s1_data)};
            FN_CTZ32: bc_result = {57'd0, ctz64({32'hFFFF_FFFF, s1_data[31:0]})};
            FN_POP64: bc_result = {57'd0, pop64(s1_data)};
            FN_POP32: bc_result = {57'd0, pop64({32'd0, s1_data[31:0]})};
            default:  bc_err    = 1'b1;
        endcase
    end

    // S2 drives the response port directly and holds while the consumer stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_err   <= 1'b0;
            s2_id    <= '0;
        end else if (s1_to_s2) begin
            s2_valid <= 1'b1;
            s2_data  <= bc_result;
            s2_err   <= bc_err;
            s2_id    <= s1_id;
        end else if (bus.rsp_ready) begin
            s2_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ops_q <= '0;
        end else if (s2_valid && bus.rsp_ready) begin
            ops_q <= ops_q + 32'd1;
        end
    end

    assign bus.rsp_valid = s2_valid;
    assign bus.rsp_data  = s2_data;
    assign bus.rsp_err   = s2_err;
    assign bus.rsp_id    = s2_id;
    assign bus.ops_count = ops_q;

endmodule

// File: tb/tb_bitcnt_arbiter.sv
// Directed bench for bitcnt_arbiter: reset, round-robin stream, backpressure,
// function sweep, unused codes and reset with both stages occupied.
module tb_bitcnt_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;
    int   exp_ops     = 0;

    bitcnt_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bif ();

    bitcnt_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One isolated request with rsp_ready high; entered and left just after a rising edge.
    task automatic run_single(input int id, input logic [2:0] f, input logic [63:0] d,
                              input logic [63:0] exp, input logic exp_err, input string tag);
        int n;
        n = 0;
        bif.req_data[64*id +: 64] = d;
        bif.req_func[3*id +: 3]   = f;
        bif.req_valid             = '0;
        bif.req_valid[id]         = 1'b1;
        #1;
        while (bif.req_ready[id] !== 1'b1 && n < 8) begin
            @(posedge clk); #2;
            n++;
        end
        check($sformatf("%s_accept", tag), 64'(bif.req_ready), 64'(1) << id);
        @(posedge clk); #1;
        bif.req_valid = '0;
        #1;
        check($sformatf("%s_lat1", tag), 64'(bif.rsp_valid), 64'd0);
        @(posedge clk); #2;
        check($sformatf("%s_valid", tag), 64'(bif.rsp_valid), 64'd1);
        check($sformatf("%s_data", tag), bif.rsp_data, exp);
        check($sformatf("%s_id", tag), 64'(bif.rsp_id), 64'(id));
        check($sformatf("%s_err", tag), 64'(bif.rsp_err), 64'(exp_err));
        exp_ops++;
        @(posedge clk); #1;
        check($sformatf("%s_ops", tag), 64'(bif.ops_count), 64'(exp_ops));
    endtask

    initial begin
        reset         = 1'b1;
        bif.req_valid = '0;
        bif.req_data  = '0;
        bif.req_func  = '0;
        bif.rsp_ready = 1'b1;

        // Reset state, with every requester asking
        @(posedge clk); #1;
        bif.req_valid = '1;
        #1;
        check("rst_req_ready", 64'(bif.req_ready), 64'd0);
        check("rst_rsp_valid", 64'(bif.rsp_valid), 64'd0);
        check("rst_rsp_id",    64'(bif.rsp_id),    64'd0);
        check("rst_rsp_data",  bif.rsp_data,       64'd0);
        check("rst_rsp_err",   64'(bif.rsp_err),   64'd0);
        check("rst_ops",       64'(bif.ops_count), 64'd0);
        bif.req_valid = '0;
        @(posedge clk); #1;
        reset = 1'b0;

        // Round-robin stream: requester i asks CTZ64 of 1<<(8*i), answer 8*i
        for (int i = 0; i < NREQ; i++) begin
            bif.req_data[64*i +: 64] = 64'd1 << (8*i);
            bif.req_func[3*i +: 3]   = 3'b010;
        end
        bif.req_valid = 4'hF;
        for (int c = 0; c < 10; c++) begin
            if (c == 8) bif.req_valid = '0;
            #1;
            if (c < 8) check($sformatf("rr_grant%0d", c), 64'(bif.req_ready), 64'(1) << (c % 4));
            if (c >= 2) begin
                check($sformatf("rr_valid%0d", c), 64'(bif.rsp_valid), 64'd1);
                check($sformatf("rr_id%0d", c),    64'(bif.rsp_id),    64'((c - 2) % 4));
                check($sformatf("rr_data%0d", c),  bif.rsp_data,       64'(8 * ((c - 2) % 4)));
                exp_ops++;
            end
            @(posedge clk); #1;
        end
        check("rr_ops8",  64'(bif.ops_count), 64'd8);
        check("rr_drain", 64'(bif.rsp_valid), 64'd0);

        // Single requester 0, CLZ64 of 0xFF
        run_single(0, 3'b000, 64'h0000_0000_0000_00FF, 64'd56, 1'b0, "t1_clz64");

        // Backpressure: requesters 1 and 3 with the consumer stalled (pointer is 1)
        bif.rsp_ready             = 1'b0;
        bif.req_data[64*1 +: 64]  = 64'hFF;
        bif.req_func[3*1 +: 3]    = 3'b100;
        bif.req_data[64*3 +: 64]  = 64'h1;
        bif.req_func[3*3 +: 3]    = 3'b000;
        bif.req_valid             = 4'b1010;
        #1;
        check("bp_grant1", 64'(bif.req_ready), 64'b0010);
        @(posedge clk); #1;
        bif.req_valid = 4'b1000;
        #1;
        check("bp_grant3", 64'(bif.req_ready), 64'b1000);
        @(posedge clk); #1;
        bif.req_data[64*1 +: 64] = 64'hF;
        bif.req_func[3*1 +: 3]   = 3'b101;
        bif.req_valid            = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("bp_ready_low%0d", c), 64'(bif.req_ready), 64'd0);
            check($sformatf("bp_valid%0d", c),     64'(bif.rsp_valid), 64'd1);
            check($sformatf("bp_id_hold%0d", c),   64'(bif.rsp_id),    64'd1);
            check($sformatf("bp_data_hold%0d", c), bif.rsp_data,       64'd8);
            @(posedge clk); #1;
        end
        bif.rsp_ready = 1'b1;
        #1;
        check("bp_release_id",    64'(bif.rsp_id),    64'd1);
        check("bp_release_data",  bif.rsp_data,       64'd8);
        check("bp_release_grant", 64'(bif.req_ready), 64'b0010);
        exp_ops++;
        @(posedge clk); #1;
        bif.req_valid = '0;
        #1;
        check("bp_drain3_valid", 64'(bif.rsp_valid), 64'd1);
        check("bp_drain3_id",    64'(bif.rsp_id),    64'd3);
        check("bp_drain3_data",  bif.rsp_data,       64'd63);
        exp_ops++;
        @(posedge clk); #2;
        check("bp_third_id",   64'(bif.rsp_id),  64'd1);
        check("bp_third_data", bif.rsp_data,     64'd4);
        check("bp_third_err",  64'(bif.rsp_err), 64'd0);
        exp_ops++;
        @(posedge clk); #2;
        check("bp_empty", 64'(bif.rsp_valid), 64'd0);
        check("bp_ops",   64'(bif.ops_count), 64'(exp_ops));
        @(posedge clk); #1;

        // Function sweep on requester 2
        run_single(2, 3'b011, 64'h0000_0001_0000_0008, 64'd3,  1'b0, "sw_ctz32");
        run_single(2, 3'b001, 64'h0000_0001_0000_0008, 64'd28, 1'b0, "sw_clz32");
        run_single(2, 3'b010, 64'h0000_0001_0000_0008, 64'd3,  1'b0, "sw_ctz64");
        run_single(2, 3'b101, 64'h0000_0001_0000_0008, 64'd1,  1'b0, "sw_pop32");
        run_single(2, 3'b100, 64'h0000_0001_0000_0008, 64'd2,  1'b0, "sw_pop64");
        run_single(2, 3'b000, 64'h0000_0001_0000_0008, 64'd31, 1'b0, "sw_clz64");
        run_single(2, 3'b011, 64'h0000_0001_0000_0000, 64'd32, 1'b0, "sw_ctz32_zero");
        run_single(2, 3'b000, 64'h0000_0000_0000_0000, 64'd64, 1'b0, "sw_clz64_zero");

        // Unused function codes, then a normal op on the same requester
        run_single(1, 3'b110, 64'hFFFF, 64'd0,  1'b1, "un_110");
        run_single(1, 3'b111, 64'hFFFF, 64'd0,  1'b1, "un_111");
        run_single(1, 3'b100, 64'hFFFF, 64'd16, 1'b0, "un_pop64");

        // Fill S1 and S2 with the consumer stalled, then reset (pointer is 2)
        bif.rsp_ready            = 1'b0;
        bif.req_data[64*0 +: 64] = 64'h1;
        bif.req_func[3*0 +: 3]   = 3'b100;
        bif.req_data[64*2 +: 64] = 64'h1;
        bif.req_func[3*2 +: 3]   = 3'b000;
        bif.req_valid            = 4'b0001;
        #1;
        check("rs_grant0", 64'(bif.req_ready), 64'b0001);
        @(posedge clk); #1;
        bif.req_valid = 4'b0100;
        #1;
        check("rs_grant2", 64'(bif.req_ready), 64'b0100);
        @(posedge clk); #1;
        bif.req_valid = '0;
        #1;
        check("rs_full_valid", 64'(bif.rsp_valid), 64'd1);
        check("rs_full_id",    64'(bif.rsp_id),    64'd0);
        reset         = 1'b1;
        bif.req_valid = 4'hF;
        #1;
        check("rs_drop_valid", 64'(bif.rsp_valid), 64'd0);
        check("rs_drop_ready", 64'(bif.req_ready), 64'd0);
        check("rs_drop_data",  bif.rsp_data,       64'd0);
        check("rs_drop_ops",   64'(bif.ops_count), 64'd0);
        exp_ops       = 0;
        bif.req_valid = '0;
        bif.rsp_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("rs_no_rsp%0d", c), 64'(bif.rsp_valid), 64'd0);
            @(posedge clk); #1;
        end
        run_single(3, 3'b011, 64'h0, 64'd32, 1'b0, "rs_req3");
        bif.req_valid = 4'hF;
        #1;
        check("rs_ptr0", 64'(bif.req_ready), 64'b0001);
        bif.req_valid = '0;
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
